// File: rtl/scope_data_responder.sv
// Scoped data responder: one data register and one saturating access counter
// per scope, serviced one request at a time over valid/ready handshakes.
module scope_data_responder #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       SCOPE_W    = 2,
  parameter int unsigned       NUM_SCOPES = 2,
  parameter logic [DATA_W-1:0] INIT_0     = DATA_W'(5),
  parameter logic [DATA_W-1:0] INIT_1     = DATA_W'(10),
  parameter int unsigned       CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SCOPE_W-1:0] req_scope,
  input  logic               req_write,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [SCOPE_W-1:0] rsp_scope,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [CNT_W-1:0]   rsp_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [DATA_W-1:0]  r_data [NUM_SCOPES];
  logic [CNT_W-1:0]   r_cnt  [NUM_SCOPES];

  logic [SCOPE_W-1:0] r_scope;
  logic               r_write;
  logic [DATA_W-1:0]  r_wdata;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [SCOPE_W-1:0] r_rsp_scope;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_rsp_count;

  logic               w_req_fire;
  logic               w_rsp_fire;
  logic               w_legal;
  logic [DATA_W-1:0]  w_cur_data;
  logic [CNT_W-1:0]   w_cur_cnt;
  logic [DATA_W-1:0]  w_new_data;
  logic [CNT_W-1:0]   w_new_cnt;

  assign w_req_fire = req_valid && r_req_ready;
  assign w_rsp_fire = r_rsp_valid && rsp_ready;
  assign w_legal    = 32'(r_scope) < NUM_SCOPES;

  // Select the captured scope's current data and count.
  always_comb begin
    w_cur_data = '0;
    w_cur_cnt  = '0;
    for (int s = 0; s < NUM_SCOPES; s++) begin
      if (r_scope == SCOPE_W'(s)) begin
        w_cur_data = r_data[s];
        w_cur_cnt  = r_cnt[s];
      end
    end
  end

  assign w_new_data = r_write ? r_wdata : w_cur_data;
  assign w_new_cnt  = (w_cur_cnt == '1) ? w_cur_cnt : w_cur_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_fire) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    if (w_rsp_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags follow the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scope <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_req_fire) begin
      r_scope <= req_scope;
      r_write <= req_write;
      r_wdata <= req_wdata;
    end
  end

  // Response payload is loaded in ACCESS and held until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_scope <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_count <= '0;
    end else if (r_state == ACCESS) begin
      r_rsp_scope <= r_scope;
      r_rsp_err   <= !w_legal;
      r_rsp_data  <= w_legal ? w_new_data : '0;
      r_rsp_count <= w_legal ? w_new_cnt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SCOPES; s++) begin
        r_data[s] <= (s == 0) ? INIT_0 : (s == 1) ? INIT_1 : '0;
        r_cnt[s]  <= '0;
      end
    end else if (r_state == ACCESS && w_legal) begin
      for (int s = 0; s < NUM_SCOPES; s++) begin
        if (r_scope == SCOPE_W'(s)) begin
          if (r_write) r_data[s] <= r_wdata;
          r_cnt[s] <= w_new_cnt;
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_scope = r_rsp_scope;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign rsp_count = r_rsp_count;

endmodule

// File: tb/tb_scope_data_responder.sv
// Scoreboard bench for scope_data_responder: a reference model predicts each
// response at request acceptance; responses are popped and compared in order.
module tb_scope_data_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_scope;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_scope;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  rsp_count;

  scope_data_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_scope (req_scope),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_scope (rsp_scope),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_count (rsp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  scope;
    logic [31:0] data;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_data [4];
  int          m_cnt  [4];
  int          cyc = 0;
  int          hs_cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data[0] = 32'd5;
    m_data[1] = 32'd10;
    m_data[2] = 32'd0;
    m_data[3] = 32'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Drive a request until accepted; on acceptance predict and queue the response.
  task automatic send(input logic [1:0] sc, input logic wr, input logic [31:0] wd,
                      input bit commit);
    exp_t e;
    bit   done = 1'b0;
    req_valid = 1'b1;
    req_scope = sc;
    req_write = wr;
    req_wdata = wd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      check("req_timeout", 64'd0, 64'd1);
    end else begin
      hs_cyc = cyc;
      if (commit) begin
        e.scope = sc;
        if (sc < 2'd2) begin
          if (wr) m_data[sc] = wd;
          if (m_cnt[sc] < 255) m_cnt[sc]++;
          e.data = m_data[sc];
          e.err  = 1'b0;
          e.cnt  = 8'(m_cnt[sc]);
        end else begin
          e.data = '0;
          e.err  = 1'b1;
          e.cnt  = '0;
        end
        sb.push_back(e);
      end
    end
  endtask

  // Accept one response and compare it with the oldest prediction.
  task automatic recv(input bit chk_lat);
    exp_t e;
    bit   done = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (chk_lat) check("latency", 64'(cyc - hs_cyc), 64'd1);
        if (sb.size() == 0) begin
          check("sb_empty", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          check("rsp_scope", 64'(rsp_scope), 64'(e.scope));
          check("rsp_data",  64'(rsp_data),  64'(e.data));
          check("rsp_err",   64'(rsp_err),   64'(e.err));
          check("rsp_count", 64'(rsp_count), 64'(e.cnt));
        end
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_scope"}, 64'(rsp_scope), 64'd0);
    check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_rsp_count"}, 64'(rsp_count), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_scope = '0;
    req_write = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Plain reads of both implemented scopes
    send(2'd0, 1'b0, 32'd0, 1'b1); recv(1'b1);
    send(2'd1, 1'b0, 32'd0, 1'b1); recv(1'b1);

    // Write then read back; other scope untouched
    send(2'd1, 1'b1, 32'h2A, 1'b1); recv(1'b0);
    send(2'd1, 1'b0, 32'd0,  1'b1); recv(1'b0);
    send(2'd0, 1'b0, 32'd0,  1'b1); recv(1'b0);

    // Out-of-range scopes, including a write that must be discarded
    send(2'd2, 1'b0, 32'd0,  1'b1); recv(1'b0);
    send(2'd3, 1'b1, 32'h99, 1'b1); recv(1'b0);
    send(2'd0, 1'b0, 32'd0,  1'b1); recv(1'b0);
    send(2'd1, 1'b0, 32'd0,  1'b1); recv(1'b0);

    // Response back-pressure with a second request waiting
    rsp_ready = 1'b0;
    send(2'd0, 1'b1, 32'h1234, 1'b1);
    req_valid = 1'b1;
    req_scope = 2'd1;
    req_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) check("hold_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data",  64'(rsp_data),  64'h1234);
      check("hold_count", 64'(rsp_count), 64'(m_cnt[0]));
      check("hold_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    recv(1'b0);
    send(2'd1, 1'b0, 32'd0, 1'b1); recv(1'b0);

    // Counter saturation on scope 0
    for (int i = 0; i < 260; i++) begin
      send(2'd0, 1'b0, 32'd0, 1'b1);
      recv(1'b0);
    end
    check("sat_count", 64'(rsp_count), 64'd255);

    // Asynchronous reset during the ACCESS cycle of a write
    send(2'd0, 1'b1, 32'h77, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(2'd0, 1'b0, 32'd0, 1'b1); recv(1'b0);
    send(2'd1, 1'b0, 32'd0, 1'b1); recv(1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
